// File: rtl/mdp_display_pkg.sv
// Shared constants for the MDP3.0 field display: register map, FSM states,
// the canned default message and the power-up digit selection table.
package mdp_display_pkg;

  localparam int REG_DATA     = 'h00;
  localparam int REG_CTRL     = 'h01;
  localparam int REG_STATUS   = 'h02;
  localparam int REG_SEL_BASE = 'h10;

  localparam int MDP_MSG_BYTES = 37;

  // First byte written by the host is the most significant byte here.
  localparam logic [8*MDP_MSG_BYTES-1:0] MDP_DEFAULT_MSG =
    296'hC0C21C023D0100006803800100007B0000000C000000A0475F3B000000000F0002C9000000;

  localparam logic [7:0] DASH_SEG = 8'h40;

  localparam logic [7:0] DEFAULT_SEL [0:7] = '{
    8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd64, 8'd65
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_UPDATE
  } state_e;

  function automatic logic [7:0] default_sel(input int i);
    if (i >= 0 && i < 8) begin
      return DEFAULT_SEL[i[2:0]];
    end
    return 8'd0;
  endfunction

  function automatic logic [7:0] default_msg_byte(input int i);
    return MDP_DEFAULT_MSG[8*(MDP_MSG_BYTES-1-i) +: 8];
  endfunction

endpackage

// File: rtl/mdp_seg_encode.sv
// Hex nibble to active-high 7-segment pattern, {dp,g,f,e,d,c,b,a}, dp always off.
module mdp_seg_encode (
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'h00;
    case (nibble)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      4'hF: seg = 8'h71;
    endcase
  end

endmodule

// File: rtl/mdp_field_display.sv
// Avalon-MM message buffer that scans selected nibbles onto 7-segment digits.
// Optional MDP_DEFAULT_MSG_EN preloads MDP_DEFAULT_MSG and self-commits after reset.
module mdp_field_display
  import mdp_display_pkg::*;
#(
  parameter int MSG_BYTES  = 37,
  parameter int NUM_DIGITS = 8,
  parameter int AW         = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    chipselect,
  input  logic                    write,
  input  logic                    read,
  input  logic [AW-1:0]           address,
  input  logic [7:0]              writedata,
  output logic [7:0]              readdata,
  output logic [8*NUM_DIGITS-1:0] hex_out,
  output logic                    busy
);

  localparam int PTR_W  = $clog2(MSG_BYTES + 1);
  localparam int BUF_AW = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [8:0] NIB_LIMIT = 9'(2 * MSG_BYTES);

`ifdef MDP_DEFAULT_MSG_EN
  if (MSG_BYTES != MDP_MSG_BYTES) begin : g_bad_msg_bytes
    $error("mdp_field_display: MDP_DEFAULT_MSG_EN requires MSG_BYTES == 37");
  end
`endif

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic [7:0]        readdata_q, readdata_d;
  logic [7:0]        buf_q [MSG_BYTES];
  logic [7:0]        buf_d [MSG_BYTES];
  logic [7:0]        sel_q [NUM_DIGITS];
  logic [7:0]        sel_d [NUM_DIGITS];

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    busy_q;
  logic [8*NUM_DIGITS-1:0] shadow_q;
  logic [8*NUM_DIGITS-1:0] hex_q;

  logic                  bus_wr, bus_rd, wr_data, wr_ctrl, full;
  logic                  host_commit, boot_commit, start;
  logic [NUM_DIGITS-1:0] sel_wr;
  logic [7:0]            rd_val;

  assign bus_wr  = chipselect & write;
  assign bus_rd  = chipselect & read;
  assign wr_data = bus_wr && (address == AW'(REG_DATA));
  assign wr_ctrl = bus_wr && (address == AW'(REG_CTRL));
  assign full    = (wr_ptr_q == PTR_W'(MSG_BYTES));

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel_dec
    assign sel_wr[gi] = bus_wr && (address == AW'(REG_SEL_BASE + gi));
  end

  assign host_commit = wr_ctrl & writedata[0] & ~busy_q;

`ifdef MDP_DEFAULT_MSG_EN
  logic boot_q, boot_d;
  assign boot_d = reset;
  always_ff @(posedge clk) boot_q <= boot_d;
  assign boot_commit = boot_q;
`else
  assign boot_commit = 1'b0;
`endif

  assign start = host_commit | boot_commit;

  // Host register file; clear is applied last so it wins over same-write error flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    buf_d      = buf_q;
    sel_d      = sel_q;
    readdata_d = readdata_q;
    rd_val     = 8'h00;

    if (wr_data) begin
      if (busy_q) begin
        err_d = 1'b1;
      end else if (full) begin
        ovf_d = 1'b1;
      end else begin
        buf_d[BUF_AW'(wr_ptr_q)] = writedata;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end

    if (wr_ctrl && writedata[0] && busy_q) begin
      err_d = 1'b1;
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_wr[i]) begin
        if (busy_q) err_d = 1'b1;
        else        sel_d[i] = writedata;
      end
    end

    if (wr_ctrl && writedata[1]) begin
      ovf_d = 1'b0;
      err_d = 1'b0;
      if (!busy_q) wr_ptr_d = '0;
    end

    if (address == AW'(REG_STATUS)) begin
      rd_val = {4'b0000, err_q, ovf_q, full, busy_q};
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (address == AW'(REG_SEL_BASE + i)) rd_val = sel_q[i];
    end
    if (bus_rd) readdata_d = rd_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef MDP_DEFAULT_MSG_EN
      wr_ptr_q <= PTR_W'(MSG_BYTES);
      for (int i = 0; i < MSG_BYTES; i++) buf_q[i] <= default_msg_byte(i);
`else
      wr_ptr_q <= '0;
      for (int i = 0; i < MSG_BYTES; i++) buf_q[i] <= 8'h00;
`endif
      for (int i = 0; i < NUM_DIGITS; i++) sel_q[i] <= default_sel(i);
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      readdata_q <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      buf_q      <= buf_d;
      sel_q      <= sel_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      readdata_q <= readdata_d;
    end
  end

  logic [7:0]        sel_cur;
  logic [BUF_AW-1:0] byte_idx;
  logic [7:0]        byte_cur;
  logic [3:0]        nib_cur;
  logic [7:0]        enc_seg, scan_seg;

  assign sel_cur  = sel_q[idx_q];
  assign byte_idx = BUF_AW'(sel_cur[7:1]);
  assign byte_cur = buf_q[byte_idx];
  assign nib_cur  = sel_cur[0] ? byte_cur[3:0] : byte_cur[7:4];

  mdp_seg_encode u_seg (
    .nibble (nib_cur),
    .seg    (enc_seg)
  );

  assign scan_seg = ({1'b0, sel_cur} >= NIB_LIMIT) ? DASH_SEG : enc_seg;

  // hex_q only moves in UPDATE, so the display never shows a half-scanned frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      shadow_q <= '0;
      hex_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SCAN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SCAN: begin
          shadow_q[8*idx_q +: 8] <= scan_seg;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) state_q <= ST_UPDATE;
          else                                 idx_q   <= idx_q + IDX_W'(1);
        end
        ST_UPDATE: begin
          hex_q   <= shadow_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hex_out  = hex_q;
  assign busy     = busy_q;
  assign readdata = readdata_q;

endmodule
